// File: rtl/systolic_wt_ctrl_pkg.sv
// Shared types and defaults for the weight-stationary systolic controller.
// State encoding is plain binary; widths default to the array build.
package systolic_wt_ctrl_pkg;

    localparam int SYSTOLIC_DATA_WIDTH = 8;
    localparam int SYSTOLIC_ARR_DIM    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_skew_buf.sv
// Per-row input skew: lane r delays {valid, data} by r cycles (lane 0 is a wire).
// Latency: r cycles on lane r.
// Backpressure: none, the chain shifts every cycle.
module systolic_skew_buf
    import systolic_wt_ctrl_pkg::*;
#(
    parameter int ARR_DIM    = SYSTOLIC_ARR_DIM,
    parameter int DATA_WIDTH = SYSTOLIC_DATA_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_vld,
    input  logic [ARR_DIM*DATA_WIDTH-1:0] i_dat,
    output logic [ARR_DIM-1:0]            o_vld,
    output logic [ARR_DIM*DATA_WIDTH-1:0] o_dat
);

    for (genvar r = 0; r < ARR_DIM; r++) begin : g_lane
        if (r == 0) begin : g_pass
            assign o_vld[0]              = i_vld;
            assign o_dat[0 +: DATA_WIDTH] = i_dat[0 +: DATA_WIDTH];
        end else begin : g_chain
            // Each stage holds {valid, data}; stage 0 is nearest the input.
            logic [DATA_WIDTH:0] r_stage [r];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int s = 0; s < r; s++) r_stage[s] <= '0;
                end else begin
                    r_stage[0] <= {i_vld, i_dat[r*DATA_WIDTH +: DATA_WIDTH]};
                    for (int s = 1; s < r; s++) r_stage[s] <= r_stage[s-1];
                end
            end

            assign o_vld[r]                       = r_stage[r-1][DATA_WIDTH];
            assign o_dat[r*DATA_WIDTH +: DATA_WIDTH] = r_stage[r-1][DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_wt_ctrl.sv
// Weight-stationary tile sequencer: weight rows, skewed A stream, drain, done pulse.
// Latency: weight pulse 1 cycle after handshake; A lane r appears r+1 cycles after handshake.
// Backpressure: w_ready/a_ready only; the array side is never stalled.
module systolic_wt_ctrl
    import systolic_wt_ctrl_pkg::*;
#(
    parameter int ARR_DIM    = SYSTOLIC_ARR_DIM,
    parameter int DATA_WIDTH = SYSTOLIC_DATA_WIDTH,
    parameter int M_WIDTH    = 16
) (
    input  logic                          s_clk,
    input  logic                          s_rst,
    input  logic                          cfg_start,
    input  logic [M_WIDTH-1:0]            cfg_m_rows,
    output logic                          busy,
    output logic                          done,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [ARR_DIM*DATA_WIDTH-1:0] w_data,
    output logic [ARR_DIM-1:0]            pe_weight_valid,
    output logic [ARR_DIM*DATA_WIDTH-1:0] pe_weights,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [ARR_DIM*DATA_WIDTH-1:0] a_data,
    output logic [ARR_DIM-1:0]            pe_in_valid,
    output logic [ARR_DIM*DATA_WIDTH-1:0] pe_in_data
);

    localparam int CW = $clog2(2*ARR_DIM);

    state_t                          r_state;
    logic [CW-1:0]                   r_row_cnt;
    logic [CW-1:0]                   r_drain_cnt;
    logic [M_WIDTH-1:0]              r_m_left;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_w_ready;
    logic                            r_a_ready;
    logic [ARR_DIM-1:0]              r_pe_wv;
    logic [ARR_DIM*DATA_WIDTH-1:0]   r_pe_weights;
    logic [ARR_DIM-1:0]              r_pe_in_valid;
    logic [ARR_DIM*DATA_WIDTH-1:0]   r_pe_in_data;

    logic                            w_w_hs;
    logic                            w_a_hs;
    logic [ARR_DIM*DATA_WIDTH-1:0]   w_skew_in_dat;
    logic [ARR_DIM-1:0]              w_skew_vld;
    logic [ARR_DIM*DATA_WIDTH-1:0]   w_skew_dat;

    assign w_w_hs = w_valid & r_w_ready;
    assign w_a_hs = a_valid & r_a_ready;
    // Invalid slots carry zeros so the array never sees stale lane data.
    assign w_skew_in_dat = w_a_hs ? a_data : '0;

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state      <= ST_IDLE;
            r_row_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_m_left     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_w_ready    <= 1'b0;
            r_a_ready    <= 1'b0;
            r_pe_wv      <= '0;
            r_pe_weights <= '0;
        end else begin
            r_done  <= 1'b0;
            r_pe_wv <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_state   <= ST_LOAD_W;
                        r_m_left  <= cfg_m_rows;
                        r_row_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_w_ready <= 1'b1;
                    end
                end
                ST_LOAD_W: begin
                    if (w_w_hs) begin
                        r_pe_weights <= w_data;
                        r_pe_wv      <= ARR_DIM'(1) << r_row_cnt;
                        if (r_row_cnt == CW'(ARR_DIM-1)) begin
                            r_row_cnt <= '0;
                            r_w_ready <= 1'b0;
                            if (r_m_left == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= ST_STREAM;
                                r_a_ready <= 1'b1;
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + CW'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_a_hs) begin
                        r_m_left <= r_m_left - M_WIDTH'(1);
                        if (r_m_left == M_WIDTH'(1)) begin
                            r_state     <= ST_DRAIN;
                            r_a_ready   <= 1'b0;
                            r_drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Window covers the skew, the column traversal and one psum register.
                    if (r_drain_cnt == CW'(2*ARR_DIM-1)) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    systolic_skew_buf #(
        .ARR_DIM    (ARR_DIM),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
        .i_clk (s_clk),
        .i_rst (s_rst),
        .i_vld (w_a_hs),
        .i_dat (w_skew_in_dat),
        .o_vld (w_skew_vld),
        .o_dat (w_skew_dat)
    );

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_pe_in_valid <= '0;
            r_pe_in_data  <= '0;
        end else begin
            r_pe_in_valid <= w_skew_vld;
            r_pe_in_data  <= w_skew_dat;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign w_ready         = r_w_ready;
    assign a_ready         = r_a_ready;
    assign pe_weight_valid = r_pe_wv;
    assign pe_weights      = r_pe_weights;
    assign pe_in_valid     = r_pe_in_valid;
    assign pe_in_data      = r_pe_in_data;

endmodule

// File: doc/systolic_wt_ctrl.md
Name: systolic_wt_ctrl

Overview:
- Weight-stationary controller for an ARR_DIM x ARR_DIM grid of systolic PEs.
- Sequences one matrix tile through the grid:
  - loads one row of B weights per array row as single-cycle valid pulses;
  - streams M A-vectors into the left edge with per-row skew;
  - waits a fixed drain window, then pulses done.
- Sits between the tile DMA/buffers and the PE grid.

Parameters:
- ARR_DIM, 16, array rows = columns; lanes per vector.
- DATA_WIDTH, `SYSTOLIC_DATA_WIDTH, width of one weight or A element.
- M_WIDTH, 16, width of the row-count config.

Ports:
- s_clk  in  1  clock
- s_rst  in  1  synchronous, active-high reset
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_m_rows  in  M_WIDTH  number of A vectors; latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- w_valid  in  1  weight-row valid
- w_ready  out  1  weight-row ready
- w_data  in  ARR_DIM*DATA_WIDTH  one B row; lane c goes to column c
- pe_weight_valid  out  ARR_DIM  one-hot; bit r drives weight_valid of every PE in array row r
- pe_weights  out  ARR_DIM*DATA_WIDTH  registered weight row, broadcast down columns
- a_valid  in  1  A-vector valid
- a_ready  out  1  A-vector ready
- a_data  in  ARR_DIM*DATA_WIDTH  one A vector; lane r goes to array row r
- pe_in_valid  out  ARR_DIM  skewed in_data_valid for left-edge PE of row r
- pe_in_data  out  ARR_DIM*DATA_WIDTH  skewed in_raw_data for left-edge PE of row r

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all counters = 0; skew registers = 0.
  - busy, done, w_ready, a_ready, pe_weight_valid, pe_in_valid = 0; pe_weights = 0.
  - Reset mid-operation aborts the tile immediately: no done pulse, skew contents discarded.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - cfg_start=1 latches cfg_m_rows into m_left and goes to LOAD_W.
  - pe_weight_valid is 0 in IDLE. This guarantees at least one low cycle before any pulse, because PEs latch on the rising edge of weight_valid.
- LOAD_W:
  - w_ready=1.
  - Handshake (w_valid & w_ready) at cycle t:
    - pe_weights <= w_data;
    - pe_weight_valid <= one-hot(row_cnt) for cycle t+1 only;
    - row_cnt increments.
  - pe_weight_valid returns to 0 on any cycle without a handshake. Gaps in w_valid are legal.
  - After handshake with row_cnt = ARR_DIM-1:
    - row_cnt wraps to 0;
    - w_ready drops the next cycle;
    - go to STREAM, or to DONE directly if m_left = 0.
- STREAM:
  - a_ready = (m_left != 0).
  - On each handshake, lane r of a_data enters a delay line of depth r; m_left decrements.
  - Lane 0 appears on pe_in_data/pe_in_valid one cycle after the handshake; lane r appears r+1 cycles after.
  - Bubbles (a_valid=0) inject pe_in_valid=0 into lane 0 and shift every lane normally.
  - The skew chain advances every cycle; there is no back-pressure into the array.
  - Handshake with m_left = 1 goes to DRAIN with drain_cnt = 0.
- DRAIN:
  - Skew chain keeps shifting zeros/invalid.
  - drain_cnt increments each cycle.
  - At drain_cnt = 2*ARR_DIM-1, go to DONE. This covers the skew, the column traversal and one PE psum register.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy falls in the same cycle done falls.
- Simultaneous events:
  - cfg_start while busy: ignored, not queued.
  - cfg_start in the DONE cycle: ignored.
  - a_valid in LOAD_W: not accepted.
  - w_valid outside LOAD_W: not accepted.
- Widths:
  - row_cnt and drain_cnt are $clog2(2*ARR_DIM) bits.
  - m_left is M_WIDTH bits and never underflows.

Decomposition:
- Shared header hyper_para.v: `SYSTOLIC_DATA_WIDTH, `SYSTOLIC_ARR_DIM, state encodings (5 states, binary).
- One sub-module, systolic_skew_buf:
  - ARR_DIM lanes; lane r is an r-stage register chain carrying {valid, data};
  - shift enable tied high;
  - synchronous reset clears all valid bits.
- The controller instantiates it once, plus one output register stage.

Test Plan:
- Reset: hold s_rst 3 cycles mid-STREAM -> next cycle all outputs 0, state IDLE, no done; a new cfg_start then completes normally.
- Weight load, ARR_DIM=4, w_valid continuous, rows 0x11..0x44:
  - pe_weight_valid = 0001, 0010, 0100, 1000 on consecutive cycles, each exactly 1 cycle;
  - pe_weights matches each row;
  - w_ready low after 4th handshake.
- Weight load with w_valid gaps (valid, idle, idle, valid...) -> each one-hot pulse 1 cycle, 0 between pulses, row order preserved.
- Stream M=3, ARR_DIM=4, a_data lanes = {k3,k2,k1,k0}, vector k accepted at cycle t_k:
  - lane r valid at t_k+r+1 with element r of vector k;
  - done exactly 2*ARR_DIM=8 cycles after entering DRAIN, plus 1 cycle for DONE.
- Stream with a_valid bubble between vectors 1 and 2 -> invalid slot propagates diagonally; data ordering intact; m_left decrements only on handshakes.
- cfg_m_rows=0 -> after 4 weight rows go to DONE directly, done pulses once, a_ready never asserted; cfg_start pulsed while busy -> no second tile.
